// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential increment, stall, halt and LUT-based
// redirects (absolute or signed PC-relative) with a one-cycle LUT read bubble.
module pc_sequencer #(
   parameter int D  = 10,
   parameter int N  = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          halt,
   input  logic          stall,
   input  logic          jump_en,
   input  logic          branch_en,
   input  logic          cond,
   input  logic          rel,
   input  logic [N-1:0]  lut_sel,
   output logic [N-1:0]  lut_addr,
   input  logic [D-1:0]  lut_target,
   output logic [D-1:0]  pc,
   output logic          fetch_valid,
   output logic          branch_taken,
   output logic          done,
   output logic [CW-1:0] redirect_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2,
      HALTED   = 2'd3
   } state_t;

   state_t        state_reg, state_next;
   logic [D-1:0]  pc_reg, pc_next;
   logic [N-1:0]  lut_addr_reg, lut_addr_next;
   logic          rel_reg, rel_next;
   logic          branch_taken_reg, branch_taken_next;
   logic [CW-1:0] cnt_reg, cnt_next;

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      lut_addr_next     = lut_addr_reg;
      rel_next          = rel_reg;
      branch_taken_next = 1'b0;
      cnt_next          = cnt_reg;
      case (state_reg)
         IDLE, HALTED: begin
            if (start) begin
               state_next = RUN;
               pc_next    = '0;
               cnt_next   = '0;
            end
         end
         RUN: begin
            if (halt) begin
               state_next = HALTED;
            end else if (stall) begin
               state_next = RUN;
            end else if (jump_en || (branch_en && cond)) begin
               lut_addr_next = lut_sel;
               rel_next      = rel;
               state_next    = REDIRECT;
            end else begin
               pc_next = pc_reg + D'(1);
            end
         end
         REDIRECT: begin
            // Target arrives from the LUT addressed last cycle; a plain D-bit
            // add gives the two's-complement relative offset for free.
            pc_next           = rel_reg ? (pc_reg + lut_target) : lut_target;
            branch_taken_next = 1'b1;
            if (cnt_reg != '1)
               cnt_next = cnt_reg + CW'(1);
            state_next = halt ? HALTED : RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg        <= IDLE;
         pc_reg           <= '0;
         lut_addr_reg     <= '0;
         rel_reg          <= 1'b0;
         branch_taken_reg <= 1'b0;
         cnt_reg          <= '0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         lut_addr_reg     <= lut_addr_next;
         rel_reg          <= rel_next;
         branch_taken_reg <= branch_taken_next;
         cnt_reg          <= cnt_next;
      end
   end

   assign pc           = pc_reg;
   assign lut_addr     = lut_addr_reg;
   assign branch_taken = branch_taken_reg;
   assign redirect_cnt = cnt_reg;
   assign done         = (state_reg == HALTED);
   assign fetch_valid  = (state_reg == RUN) && !stall && !halt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one task per feature, inline checks,
// inputs driven on the falling edge and outputs sampled 1 time unit later.
module tb_pc_sequencer;

   localparam int D  = 10;
   localparam int N  = 4;
   localparam int CW = 16;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic          halt;
   logic          stall;
   logic          jump_en;
   logic          branch_en;
   logic          cond;
   logic          rel;
   logic [N-1:0]  lut_sel;
   logic [N-1:0]  lut_addr;
   logic [D-1:0]  lut_target;
   logic [D-1:0]  pc;
   logic          fetch_valid;
   logic          branch_taken;
   logic          done;
   logic [CW-1:0] redirect_cnt;

   logic [D-1:0]  lut_mem [16];
   int            total;
   int            bad;

   pc_sequencer #(.D(D), .N(N), .CW(CW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .halt         (halt),
      .stall        (stall),
      .jump_en      (jump_en),
      .branch_en    (branch_en),
      .cond         (cond),
      .rel          (rel),
      .lut_sel      (lut_sel),
      .lut_addr     (lut_addr),
      .lut_target   (lut_target),
      .pc           (pc),
      .fetch_valid  (fetch_valid),
      .branch_taken (branch_taken),
      .done         (done),
      .redirect_cnt (redirect_cnt)
   );

   // Bench-side branch-target LUT, combinational from lut_addr
   assign lut_target = lut_mem[lut_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic advance(input int n);
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   task automatic clear_ctl();
      start = 0; halt = 0; stall = 0; jump_en = 0;
      branch_en = 0; cond = 0; rel = 0; lut_sel = '0;
   endtask

   // Reset, then start: returns at a falling edge with pc=0 in RUN
   task automatic restart();
      clear_ctl();
      reset_n = 0;
      next_cycle();
      reset_n = 1;
      start = 1;
      next_cycle();
      start = 0;
   endtask

   task automatic test_reset();
      clear_ctl();
      reset_n = 0;
      next_cycle();
      next_cycle();
      #1;
      total++; if (pc !== 10'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
      total++; if (lut_addr !== 4'd0) begin bad++; $display("FAIL reset_lut_addr: got %0d want 0", lut_addr); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL reset_bt: got %b want 0", branch_taken); end
      total++; if (redirect_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", redirect_cnt); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_fv: got %b want 0", fetch_valid); end
      start = 1;
      next_cycle();
      #1;
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL reset_over_start_fv: got %b want 0", fetch_valid); end
      start = 0;
      $display("test_reset: done");
   endtask

   task automatic test_basic();
      reset_n = 1;
      start = 1;
      next_cycle();
      start = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (pc !== D'(i)) begin bad++; $display("FAIL basic_pc: got %0d want %0d", pc, i); end
         total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL basic_fv: got %b want 1", fetch_valid); end
         total++; if (done !== 1'b0 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL basic_done_cnt: got done=%b cnt=%0d want 0/0", done, redirect_cnt); end
         next_cycle();
      end
      start = 1;
      next_cycle();
      start = 0;
      #1;
      total++; if (pc !== 10'd6) begin bad++; $display("FAIL start_in_run: got %0d want 6", pc); end
      $display("test_basic: done");
   endtask

   task automatic test_abs_jump();
      restart();
      advance(3);
      jump_en = 1; rel = 0; lut_sel = 4'd2;
      #1;
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL abs_req_fv: got %b want 1", fetch_valid); end
      next_cycle();
      jump_en = 0; lut_sel = 4'd0;
      #1;
      total++; if (lut_addr !== 4'd2) begin bad++; $display("FAIL abs_lut_addr: got %0d want 2", lut_addr); end
      total++; if (pc !== 10'd3) begin bad++; $display("FAIL abs_bubble_pc: got %0d want 3", pc); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL abs_bubble_fv: got %b want 0", fetch_valid); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd44) begin bad++; $display("FAIL abs_pc: got %0d want 44", pc); end
      total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL abs_bt: got %b want 1", branch_taken); end
      total++; if (redirect_cnt !== 16'd1) begin bad++; $display("FAIL abs_cnt: got %0d want 1", redirect_cnt); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd45) begin bad++; $display("FAIL abs_after_pc: got %0d want 45", pc); end
      total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL abs_bt_pulse: got %b want 0", branch_taken); end
      $display("test_abs_jump: done");
   endtask

   task automatic test_priority();
      restart();
      advance(2);
      jump_en = 1; branch_en = 1; cond = 0; rel = 0; lut_sel = 4'd2;
      next_cycle();
      clear_ctl();
      stall = 1;
      #1;
      total++; if (pc !== 10'd2) begin bad++; $display("FAIL prio_bubble_pc: got %0d want 2", pc); end
      next_cycle();
      stall = 0;
      #1;
      total++; if (pc !== 10'd44) begin bad++; $display("FAIL prio_jump_wins: got %0d want 44", pc); end
      $display("test_priority: done");
   endtask

   task automatic test_rel_branch();
      restart();
      advance(6);
      branch_en = 1; cond = 1; rel = 1; lut_sel = 4'd9;
      next_cycle();
      branch_en = 0; cond = 0; rel = 0; lut_sel = 4'd0;
      #1;
      total++; if (pc !== 10'd6 || lut_addr !== 4'd9) begin bad++; $display("FAIL rel_bubble: got pc=%0d addr=%0d want 6/9", pc, lut_addr); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rel_bubble_fv: got %b want 0", fetch_valid); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd1) begin bad++; $display("FAIL rel_pc: got %0d want 1", pc); end
      total++; if (branch_taken !== 1'b1 || redirect_cnt !== 16'd1) begin bad++; $display("FAIL rel_bt_cnt: got bt=%b cnt=%0d want 1/1", branch_taken, redirect_cnt); end
      next_cycle();
      branch_en = 1; cond = 0; rel = 1; lut_sel = 4'd5;
      #1;
      total++; if (pc !== 10'd2 || fetch_valid !== 1'b1) begin bad++; $display("FAIL nt_req: got pc=%0d fv=%b want 2/1", pc, fetch_valid); end
      next_cycle();
      clear_ctl();
      #1;
      total++; if (pc !== 10'd3) begin bad++; $display("FAIL nt_pc: got %0d want 3", pc); end
      total++; if (lut_addr !== 4'd9) begin bad++; $display("FAIL nt_lut_addr: got %0d want 9", lut_addr); end
      total++; if (branch_taken !== 1'b0 || redirect_cnt !== 16'd1) begin bad++; $display("FAIL nt_bt_cnt: got bt=%b cnt=%0d want 0/1", branch_taken, redirect_cnt); end
      $display("test_rel_branch: done");
   endtask

   task automatic test_wrap();
      restart();
      advance(1023);
      #1;
      total++; if (pc !== 10'd1023) begin bad++; $display("FAIL wrap_top: got %0d want 1023", pc); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", pc); end
      restart();
      advance(1020);
      branch_en = 1; cond = 1; rel = 1; lut_sel = 4'd3;
      next_cycle();
      clear_ctl();
      next_cycle();
      #1;
      total++; if (pc !== 10'd8) begin bad++; $display("FAIL wrap_rel: got %0d want 8", pc); end
      $display("test_wrap: done");
   endtask

   task automatic test_stall_halt();
      restart();
      advance(7);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (pc !== 10'd7 || fetch_valid !== 1'b0) begin bad++; $display("FAIL stall: got pc=%0d fv=%b want 7/0", pc, fetch_valid); end
         next_cycle();
      end
      stall = 0;
      next_cycle();
      #1;
      total++; if (pc !== 10'd8) begin bad++; $display("FAIL stall_release: got %0d want 8", pc); end
      halt = 1; stall = 1;
      #1;
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL halt_fv: got %b want 0", fetch_valid); end
      next_cycle();
      halt = 0; stall = 0;
      #1;
      total++; if (done !== 1'b1 || pc !== 10'd8) begin bad++; $display("FAIL halted: got done=%b pc=%0d want 1/8", done, pc); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd8 || fetch_valid !== 1'b0) begin bad++; $display("FAIL halted_hold: got pc=%0d fv=%b want 8/0", pc, fetch_valid); end
      start = 1;
      next_cycle();
      start = 0;
      #1;
      total++; if (pc !== 10'd0 || done !== 1'b0) begin bad++; $display("FAIL halt_restart: got pc=%0d done=%b want 0/0", pc, done); end
      $display("test_stall_halt: done");
   endtask

   task automatic test_halt_in_redirect();
      restart();
      advance(2);
      jump_en = 1; lut_sel = 4'd2;
      next_cycle();
      clear_ctl();
      halt = 1;
      next_cycle();
      halt = 0;
      #1;
      total++; if (pc !== 10'd44 || branch_taken !== 1'b1) begin bad++; $display("FAIL hr_pc_bt: got pc=%0d bt=%b want 44/1", pc, branch_taken); end
      total++; if (done !== 1'b1 || redirect_cnt !== 16'd1) begin bad++; $display("FAIL hr_done_cnt: got done=%b cnt=%0d want 1/1", done, redirect_cnt); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd44 || lut_addr !== 4'd2 || done !== 1'b1) begin bad++; $display("FAIL hr_hold: got pc=%0d addr=%0d done=%b want 44/2/1", pc, lut_addr, done); end
      start = 1;
      next_cycle();
      start = 0;
      #1;
      total++; if (pc !== 10'd0 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL hr_restart: got pc=%0d cnt=%0d want 0/0", pc, redirect_cnt); end
      total++; if (done !== 1'b0 || fetch_valid !== 1'b1) begin bad++; $display("FAIL hr_restart_flags: got done=%b fv=%b want 0/1", done, fetch_valid); end
      $display("test_halt_in_redirect: done");
   endtask

   task automatic test_reset_mid();
      restart();
      advance(3);
      jump_en = 1; lut_sel = 4'd2;
      next_cycle();
      clear_ctl();
      next_cycle();
      jump_en = 1; lut_sel = 4'd2;
      next_cycle();
      clear_ctl();
      reset_n = 0;
      #1;
      total++; if (pc !== 10'd44 || lut_addr !== 4'd2 || redirect_cnt !== 16'd1) begin bad++; $display("FAIL rm_pre_edge: got pc=%0d addr=%0d cnt=%0d want 44/2/1", pc, lut_addr, redirect_cnt); end
      next_cycle();
      #1;
      total++; if (pc !== 10'd0 || lut_addr !== 4'd0) begin bad++; $display("FAIL rm_pc_addr: got pc=%0d addr=%0d want 0/0", pc, lut_addr); end
      total++; if (branch_taken !== 1'b0 || redirect_cnt !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL rm_flags: got bt=%b cnt=%0d done=%b want 0/0/0", branch_taken, redirect_cnt, done); end
      reset_n = 1;
      jump_en = 1; lut_sel = 4'd7;
      #1;
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rm_idle_fv: got %b want 0", fetch_valid); end
      next_cycle();
      next_cycle();
      #1;
      total++; if (pc !== 10'd0 || lut_addr !== 4'd0 || fetch_valid !== 1'b0) begin bad++; $display("FAIL rm_idle: got pc=%0d addr=%0d fv=%b want 0/0/0", pc, lut_addr, fetch_valid); end
      clear_ctl();
      $display("test_reset_mid: done");
   endtask

   initial begin
      total = 0;
      bad = 0;
      for (int i = 0; i < 16; i++) lut_mem[i] = '0;
      lut_mem[2] = 10'd44;
      lut_mem[9] = 10'h3FB;
      lut_mem[3] = 10'd12;
      clear_ctl();
      reset_n = 0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_abs_jump();
      test_priority();
      test_rel_branch();
      test_wrap();
      test_stall_halt();
      test_halt_in_redirect();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
